mem_arb: RTL
============

# mem_arb

Single-ported memory arbiter that shares one multi-cycle unified memory between the processor's instruction-fetch port and its data-memory port. It sits between `proc` and the memory model, converts level-held requests into one-cycle memory issues, and returns stall/done handshakes to each side. It also flags protocol faults and hung memory accesses on `err`.

## Interface
- TIMEOUT, 16: maximum BUSY cycles allowed without `mem_done` before abort; legal range 2..255.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_rd  in  1  fetch read request, level-held until `if_done`.
- if_addr  in  16  fetch byte address.
- if_rdata  out  16  fetched instruction, valid while `if_done`=1.
- if_stall  out  1  `if_rd & ~if_done`.
- if_done  out  1  one-cycle completion strobe for fetch.
- dm_rd  in  1  data read request, level-held until `dm_done`.
- dm_wr  in  1  data write request, level-held until `dm_done`.
- dm_addr  in  16  data byte address.
- dm_wdata  in  16  write data.
- dm_rdata  out  16  load data, valid while `dm_done`=1 after a read.
- dm_stall  out  1  `(dm_rd | dm_wr) & ~dm_done`.
- dm_done  out  1  one-cycle completion strobe for data.
- mem_en  out  1  one-cycle issue pulse to memory.
- mem_wr  out  1  1 = write, 0 = read; held for the whole access.
- mem_addr  out  16  registered address, held for the whole access.
- mem_wdata  out  16  registered write data, held for the whole access.
- mem_rdata  in  16  memory read data, valid with `mem_done`.
- mem_done  in  1  one-cycle completion pulse from memory.
- err  out  1  sticky fault flag, cleared only by `rst`.

## Operation
- The block has four states. IDLE, IF_BUSY and DM_BUSY are encoded in 2 bits, with RESP as the fourth.
- IDLE:
  - If any data request is present (`dm_rd | dm_wr`), grant data and go to DM_BUSY.
  - Otherwise, if `if_rd`=1, grant fetch and go to IF_BUSY.
  - Data always has priority, because it is the older instruction.
- Grant edge:
  - Register `mem_addr`, `mem_wdata` and `mem_wr`.
  - Clear the timeout counter (8-bit).
  - Set `mem_en`=1 for the first BUSY cycle only.
- Fault at grant:
  - A fault is either `dm_rd & dm_wr`, or a granted address with bit 0 = 1.
  - On a fault, set `err`, suppress `mem_en`, and go directly to RESP with response data 0.
- BUSY:
  - Each cycle, the counter increments.
  - `mem_done` is accepted in any BUSY cycle, including the issue cycle.
  - On `mem_done`: capture `mem_rdata` (reads only) into the response register and go to RESP.
  - If the counter reaches TIMEOUT-1 without `mem_done`: set `err`, set response data to 0, and go to RESP.
- RESP:
  - Lasts exactly one cycle.
  - Assert `if_done` or `dm_done` for the granted side.
  - Drive the response register onto that side's rdata.
  - Go to IDLE.
  - Requests are ignored in RESP, so a requester updating its request on the done edge is never re-granted its old access.
- Writes: `dm_done` pulses; `dm_rdata` keeps its previous value.
- `mem_done` outside BUSY is ignored and does not set `err`.
- Changes to the non-granted requester's inputs during BUSY have no effect until IDLE.

## Timing
- Reset values: state IDLE, counter 0, and all outputs 0 (`mem_*`, rdata, done, `err`). Stall outputs follow their combinational definitions.
- Reset mid-access: the state returns to IDLE and `mem_en` drops immediately (asynchronous). The pending memory access is abandoned.
- Latency for a request seen in IDLE at cycle 0, with memory answering N cycles after issue:
  - Cycle 1: `mem_en`=1.
  - Cycle 1+N: `mem_done`.
  - Cycle 2+N: done strobe.
  - Cycle 3+N: IDLE.
- Minimum (N=0): done strobe at cycle 2; next grant no earlier than cycle 3.
- Back-to-back: a request pending during RESP is granted in the following IDLE cycle. This gives a peak throughput of one access per 3 cycles.
- Timeout: with no `mem_done`, `err` rises and RESP is entered after TIMEOUT BUSY cycles.
- Simultaneous data and fetch requests: data is served first. Fetch stays stalled and is granted in the IDLE cycle after data's RESP.

## Test plan
- Reset, then a fetch read:
  - Stimulus: `if_rd`=1, `if_addr`=0x0000; memory returns 0xc010 with N=2.
  - Response: `mem_en` at cycle 1 with `mem_addr`=0x0000. `if_done`=1 and `if_rdata`=0xc010 at cycle 4. `if_stall`=1 on cycles 0-3, then 0.
- Simultaneous requests:
  - Stimulus: `if_rd` at 0x0002 and `dm_wr` at 0x0040 with `dm_wdata`=0x0011.
  - Response: first issue has `mem_wr`=1, `mem_addr`=0x0040, `mem_wdata`=0x0011. `dm_done` pulses. The fetch issue follows with `mem_addr`=0x0002. `dm_rdata` is unchanged.
- Load data return:
  - Stimulus: `dm_rd` at 0x0040; memory returns 0x0011 on the issue cycle (N=0).
  - Response: `dm_done` with `dm_rdata`=0x0011 exactly 2 cycles after the request is seen.
- Misaligned access:
  - Stimulus: `dm_rd` at 0x0041.
  - Response: no `mem_en`; `err`=1 one cycle later; `dm_done` with `dm_rdata`=0. `err` stays 1 through later good accesses until `rst`.
- Hung memory:
  - Stimulus: TIMEOUT=4 and `mem_done` never asserted.
  - Response: `err` rises after 4 BUSY cycles, `if_done` follows with `if_rdata`=0, and the state returns to IDLE. A late stray `mem_done` is ignored.
- Mid-access reset:
  - Stimulus: `rst` asserted during DM_BUSY.
  - Response: all outputs 0 immediately. After release, a held `if_rd` is granted normally and the old data access is never completed.

Source files
------------

// File: rtl/mem_arb.sv
// mem_arb -- shares one single-ported, multi-cycle memory between the fetch
// port (if_*) and the data port (dm_*).
//
// Requests are level-held by the requester until its done strobe. The arbiter
// grants one access from IDLE. Data has priority over fetch. For each access it
// drives a one-cycle mem_en issue pulse, waits in a BUSY state for mem_done, and
// then spends one RESP cycle returning the done strobe and read data.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   if_rd, if_addr                 fetch request (level) and byte address
//   if_rdata, if_stall, if_done    fetch response data, stall, done strobe
//   dm_rd, dm_wr, dm_addr, dm_wdata data request (level), address, write data
//   dm_rdata, dm_stall, dm_done    data response data, stall, done strobe
//   mem_en, mem_wr, mem_addr, mem_wdata  memory issue (en is a pulse, rest held)
//   mem_rdata, mem_done            memory read data and completion pulse
//   err                            sticky fault flag (protocol fault or timeout)
module mem_arb #(
  parameter int TIMEOUT = 16  // BUSY cycles allowed before abort, 2..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_rd,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_stall,
  output logic        if_done,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_stall,
  output logic        dm_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [7:0]  cnt;
  logic        gnt_dm;    // granted side of the access in flight (1 = data)
  logic        rd_q;      // access in flight is a read

  // next-state / grant decode
  logic        grant;
  logic        gnt_dm_n;
  logic        fault;
  logic [15:0] g_addr;
  logic        tmo;
  logic        enter_resp;
  logic        resp_dm;
  logic        resp_rd;
  logic [15:0] resp_data;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // ---------------------------------------------------------------------------
  // Next-state and response decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n   = state;
    grant     = 1'b0;
    gnt_dm_n  = 1'b0;
    fault     = 1'b0;
    g_addr    = if_addr;
    tmo       = 1'b0;
    resp_dm   = gnt_dm;
    resp_rd   = rd_q;
    resp_data = '0;

    case (state)
      IDLE: begin
        if (dm_rd | dm_wr) begin
          grant    = 1'b1;
          gnt_dm_n = 1'b1;
          g_addr   = dm_addr;
          fault    = (dm_rd & dm_wr) | dm_addr[0];
        end else if (if_rd) begin
          grant    = 1'b1;
          fault    = if_addr[0];
        end
        if (grant) begin
          // A faulted grant never reaches memory; it answers with zero data
          // straight from RESP.
          state_n = fault ? RESP : (gnt_dm_n ? DM_BUSY : IF_BUSY);
          resp_dm = gnt_dm_n;
          resp_rd = gnt_dm_n ? dm_rd : 1'b1;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (mem_done) begin
          state_n   = RESP;
          resp_data = mem_rdata;
        end else if (cnt == TMO_LAST) begin
          state_n = RESP;
          tmo     = 1'b1;
        end
      end
      RESP: state_n = IDLE;  // requests are deliberately not looked at here
      default: state_n = IDLE;
    endcase

    enter_resp = (state_n == RESP) && (state != RESP);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      gnt_dm    <= 1'b0;
      rd_q      <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      // issue pulse covers only the first BUSY cycle
      mem_en <= grant & ~fault;

      if (grant) begin
        cnt       <= '0;
        gnt_dm    <= gnt_dm_n;
        rd_q      <= ~(gnt_dm_n & dm_wr);
        mem_wr    <= gnt_dm_n & dm_wr;
        mem_addr  <= g_addr;
        mem_wdata <= gnt_dm_n ? dm_wdata : '0;
      end else if (state == IF_BUSY || state == DM_BUSY) begin
        cnt <= cnt + 8'd1;
      end

      if ((grant & fault) | tmo) err <= 1'b1;

      if_done <= enter_resp & ~resp_dm;
      dm_done <= enter_resp &  resp_dm;

      // Writes leave the previous load data visible on dm_rdata.
      if (enter_resp && resp_rd) begin
        if (resp_dm) dm_rdata <= resp_data;
        else         if_rdata <= resp_data;
      end
    end
  end

  assign if_stall = if_rd & ~if_done;
  assign dm_stall = (dm_rd | dm_wr) & ~dm_done;

endmodule
